// File: rtl/chnl_rx_fifo.sv
// chnl_rx_fifo: responder end of a channel valid/ready link, buffering words in a FWFT FIFO
//   clk_i, rst_i           clock, synchronous active-high reset
//   en_i                   channel enable, gates acceptance only
//   ch_data_i/ch_valid_i   initiator word and valid
//   ch_ready_o             responder can accept this cycle
//   ch_margin_o            registered free-entry count
//   a_val_o/a_data_o       head-of-FIFO word, first-word-fall-through
//   a_pop_i                arbiter consumes the head word
//   acc_cnt_o              registered accepted-word counter
module chnl_rx_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int MW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [DW-1:0] ch_data_i,
    input  logic          ch_valid_i,
    output logic          ch_ready_o,
    output logic [MW-1:0] ch_margin_o,
    output logic          a_val_o,
    output logic [DW-1:0] a_data_o,
    input  logic          a_pop_i,
    output logic [15:0]   acc_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [MW-1:0] r_count, r_margin, w_count_next;
    logic [15:0]   r_acc_cnt;
    logic          w_push, w_pop;
    // Full blocks ready even when a pop is pending: no full bypass.
    assign ch_ready_o   = !rst_i && en_i && (r_count != MW'(DEPTH));
    assign a_val_o      = (r_count != '0);
    assign a_data_o     = a_val_o ? r_mem[r_rd_ptr] : '0;
    assign w_push       = ch_valid_i && ch_ready_o;
    // Pop needs a stored word, so a push into an empty FIFO is never popped in the same cycle.
    assign w_pop        = a_pop_i && a_val_o;
    assign w_count_next = r_count + MW'(w_push) - MW'(w_pop);
    assign ch_margin_o  = r_margin;
    assign acc_cnt_o    = r_acc_cnt;
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= ch_data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_margin  <= MW'(DEPTH);
            r_acc_cnt <= '0;
        end else begin
            r_wr_ptr  <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr  <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count   <= w_count_next;
            r_margin  <= MW'(DEPTH) - w_count_next;
            r_acc_cnt <= w_push ? r_acc_cnt + 16'd1 : r_acc_cnt;
        end
    end
endmodule

// File: tb/tb_chnl_rx_fifo.sv
// tb_chnl_rx_fifo: directed vector table plus hand-written corner sequences for chnl_rx_fifo
module tb_chnl_rx_fifo;
    logic        clk_i = 1'b0, rst_i = 1'b1, en_i = 1'b1, ch_valid_i = 1'b0, a_pop_i = 1'b0;
    logic [31:0] ch_data_i = '0;
    logic        ch_ready_o, a_val_o;
    logic [5:0]  ch_margin_o;
    logic [31:0] a_data_o;
    logic [15:0] acc_cnt_o;
    int n_cmp = 0, n_bad = 0;
    chnl_rx_fifo dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .ch_data_i(ch_data_i),
        .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o), .ch_margin_o(ch_margin_o),
        .a_val_o(a_val_o), .a_data_o(a_data_o), .a_pop_i(a_pop_i), .acc_cnt_o(acc_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    typedef struct {
        logic        rst, en, vld;
        logic [31:0] d;
        logic        pop, rdy;
        logic [5:0]  mg;
        logic        av;
        logic [31:0] ad;
        logic [15:0] acc;
    } vec_t;
    vec_t tv[14];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic cyc(input logic e, input logic v, input logic [31:0] d, input logic p);
        @(negedge clk_i);
        rst_i = 1'b0; en_i = e; ch_valid_i = v; ch_data_i = d; a_pop_i = p;
        #1;
    endtask
    initial begin
        //           rst   en    vld   d          pop   rdy   mg  av    ad         acc
        tv[0]  = '{1'b1, 1'b1, 1'b1, 32'hA0,    1'b0, 1'b0, 32, 1'b0, 32'h0,     16'd0};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 32'hA1,    1'b0, 1'b0, 32, 1'b0, 32'h0,     16'd0};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 32'hA2,    1'b0, 1'b0, 32, 1'b0, 32'h0,     16'd0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 32'h11,    1'b0, 1'b1, 32, 1'b0, 32'h0,     16'd0};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 32'h22,    1'b1, 1'b1, 31, 1'b1, 32'h11,    16'd1};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 31, 1'b1, 32'h22,    16'd2};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32, 1'b0, 32'h0,     16'd2};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 32'h33,    1'b1, 1'b1, 32, 1'b0, 32'h0,     16'd2};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 32'h44,    1'b0, 1'b0, 31, 1'b1, 32'h33,    16'd3};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 32'h44,    1'b1, 1'b0, 31, 1'b1, 32'h33,    16'd3};
        tv[10] = '{1'b0, 1'b0, 1'b1, 32'h44,    1'b0, 1'b0, 32, 1'b0, 32'h0,     16'd3};
        tv[11] = '{1'b0, 1'b1, 1'b1, 32'h55,    1'b0, 1'b1, 32, 1'b0, 32'h0,     16'd3};
        tv[12] = '{1'b1, 1'b1, 1'b1, 32'h66,    1'b0, 1'b0, 31, 1'b1, 32'h55,    16'd4};
        tv[13] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32, 1'b0, 32'h0,     16'd0};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            rst_i = tv[i].rst; en_i = tv[i].en; ch_valid_i = tv[i].vld;
            ch_data_i = tv[i].d; a_pop_i = tv[i].pop;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(ch_ready_o), 32'(tv[i].rdy));
            chk($sformatf("v%0d_margin", i), 32'(ch_margin_o), 32'(tv[i].mg));
            chk($sformatf("v%0d_val", i), 32'(a_val_o), 32'(tv[i].av));
            chk($sformatf("v%0d_data", i), a_data_o, tv[i].ad);
            chk($sformatf("v%0d_acc", i), 32'(acc_cnt_o), 32'(tv[i].acc));
        end
        for (int k = 0; k < 100; k++) begin
            cyc(1, 1, 32'h00C0_0000 + k, 1);
            chk("t2_rdy", 32'(ch_ready_o), 1);
            if (k > 0) begin
                chk("t2_val", 32'(a_val_o), 1);
                chk("t2_data", a_data_o, 32'h00C0_0000 + k - 1);
            end
        end
        cyc(1, 0, 0, 1);
        chk("t2_last", a_data_o, 32'h00C0_0063);
        cyc(1, 0, 0, 0);
        chk("t2_acc", 32'(acc_cnt_o), 100);
        chk("t2_margin", 32'(ch_margin_o), 32);
        chk("t2_empty", 32'(a_val_o), 0);
        for (int i = 0; i < 32; i++) begin
            cyc(1, 1, 32'hF000 + i, 0);
            chk("t3_rdy", 32'(ch_ready_o), 1);
            chk("t3_margin", 32'(ch_margin_o), 32 - i);
        end
        cyc(1, 1, 32'hF020, 0);
        chk("t3_full_rdy", 32'(ch_ready_o), 0);
        chk("t3_full_margin", 32'(ch_margin_o), 0);
        chk("t3_head", a_data_o, 32'hF000);
        cyc(1, 1, 32'hF020, 1);
        chk("t3_no_bypass", 32'(ch_ready_o), 0);
        cyc(1, 1, 32'hF020, 0);
        chk("t3_rdy_back", 32'(ch_ready_o), 1);
        chk("t3_margin1", 32'(ch_margin_o), 1);
        chk("t3_head1", a_data_o, 32'hF001);
        cyc(1, 0, 0, 0);
        chk("t3_refull_margin", 32'(ch_margin_o), 0);
        chk("t3_refull_rdy", 32'(ch_ready_o), 0);
        chk("t3_acc", 32'(acc_cnt_o), 133);
        for (int j = 1; j <= 32; j++) begin
            cyc(1, 0, 0, 1);
            chk("t3_drain_val", 32'(a_val_o), 1);
            chk("t3_drain_data", a_data_o, 32'hF000 + j);
        end
        cyc(1, 0, 0, 0);
        chk("t3_empty", 32'(a_val_o), 0);
        chk("t3_margin_end", 32'(ch_margin_o), 32);
        for (int i = 0; i < 16; i++) cyc(1, 1, 32'hD000 + i, 0);
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, 32'hD010 + k, 1);
            chk("t4_margin", 32'(ch_margin_o), 16);
            chk("t4_data", a_data_o, 32'hD000 + k);
        end
        for (int j = 0; j < 16; j++) begin
            cyc(1, 0, 0, 1);
            chk("t4_drain", a_data_o, 32'hD028 + j);
        end
        cyc(1, 0, 0, 0);
        chk("t4_empty", 32'(a_val_o), 0);
        chk("t4_acc", 32'(acc_cnt_o), 189);
        chk("t4_margin_end", 32'(ch_margin_o), 32);
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'hE000 + i, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 32'hBAD, k < 3);
            chk("t5_rdy", 32'(ch_ready_o), 0);
            chk("t5_acc", 32'(acc_cnt_o), 192);
            chk("t5_margin", 32'(ch_margin_o), k < 3 ? 29 + k : 32);
            if (k < 3) chk("t5_drain", a_data_o, 32'hE000 + k);
        end
        cyc(0, 0, 0, 0);
        chk("t5_empty", 32'(a_val_o), 0);
        chk("t5_acc_end", 32'(acc_cnt_o), 192);
        for (int i = 0; i < 10; i++) cyc(1, 1, 32'hA000 + i, 0);
        cyc(1, 0, 0, 0);
        chk("t6_margin_pre", 32'(ch_margin_o), 22);
        chk("t6_val_pre", 32'(a_val_o), 1);
        @(negedge clk_i);
        rst_i = 1'b1; en_i = 1'b1; ch_valid_i = 1'b1; ch_data_i = 32'h77; a_pop_i = 1'b0;
        #1;
        chk("t6_rst_rdy", 32'(ch_ready_o), 0);
        cyc(1, 0, 0, 0);
        chk("t6_val", 32'(a_val_o), 0);
        chk("t6_margin", 32'(ch_margin_o), 32);
        chk("t6_acc", 32'(acc_cnt_o), 0);
        chk("t6_data", a_data_o, 0);
        cyc(1, 1, 32'h99, 0);
        cyc(1, 0, 0, 0);
        chk("t6_fresh_val", 32'(a_val_o), 1);
        chk("t6_fresh_data", a_data_o, 32'h99);
        chk("t6_fresh_margin", 32'(ch_margin_o), 31);
        chk("t6_fresh_acc", 32'(acc_cnt_o), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
